// File: rtl/heater_enable_ctrl.sv
// heater_enable_ctrl: drives the 32-bit heater bank enable vector.
// Banks are switched in and out one at a time on a fixed step interval.
// This keeps supply current from jumping by more than one bank per step.
// A PWM gate with 2^PWM_BITS slots modulates the average heat.
// Optional watchdog: define HEATER_CTRL_WATCHDOG_EN.
// When the watchdog trips, it drops every bank at once and raises a sticky fault.
module heater_enable_ctrl #(
    parameter int WIDTH       = 32,
    parameter int STEP_CYCLES = 1000,
    parameter int PWM_BITS    = 4,
    parameter int WDOG_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [5:0]          target_banks,
    input  logic [PWM_BITS-1:0] duty,
    output logic [WIDTH-1:0]    enable,
    output logic [5:0]          active_count,
    output logic                busy,
    output logic                fault
);

    localparam int               TMR_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_CYCLES - 1);
    localparam logic [5:0]       MAX_BANKS  = 6'(WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          active_q, active_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                stopping_q, stopping_d;
    logic [WIDTH-1:0]    enable_q, enable_d;
    logic                fault_q, fault_d;

    logic [5:0]          tgt_clamped;
    logic [5:0]          goal;
    logic [5:0]          step_val;
    state_t              step_state;
    logic                start_acc;
    logic                stop_now;
    logic                do_step;
    logic                wdog_trip;
    logic                pwm_on;
    logic [WIDTH-1:0]    therm;

    // Work out where the ramp is heading and what a single step toward that goal produces.
    always_comb begin
        tgt_clamped = (target_banks > MAX_BANKS) ? MAX_BANKS : target_banks;
        // Accept start only without stop and only when it can do something.
        // In IDLE it needs a non-zero target; otherwise no stop may be pending.
        start_acc   = start && !stop &&
                      ((state_q == IDLE) ? (tgt_clamped != 6'd0) : !stopping_q);
        // Apply a fresh stop in the same cycle, so ramp-down from HOLD starts immediately.
        stop_now    = stopping_q || (stop && (state_q != IDLE));
        goal        = stop_now ? 6'd0 : tgt_clamped;

        if (goal > active_q) begin
            step_val = active_q + 6'd1;
        end else if (goal < active_q) begin
            step_val = active_q - 6'd1;
        end else begin
            step_val = active_q;
        end

        if (step_val == goal) begin
            step_state = (step_val == 6'd0) ? IDLE : HOLD;
        end else begin
            step_state = (goal > active_q) ? RAMP_UP : RAMP_DOWN;
        end
    end

    // Next-state logic: choose when to step, and update the step timer and stop latch.
    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        timer_d    = timer_q;
        stopping_d = stopping_q || (stop && (state_q != IDLE));
        do_step    = 1'b0;

        case (state_q)
            IDLE:              do_step = start_acc;
            HOLD:              do_step = (goal != active_q);
            RAMP_UP, RAMP_DOWN: do_step = (timer_q == '0);
            default:           do_step = 1'b0;
        endcase

        if (do_step) begin
            state_d  = step_state;
            active_d = step_val;
            timer_d  = TMR_RELOAD;
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end

        // On a watchdog trip, drop all banks at once with no ramp-down.
        if (wdog_trip) begin
            state_d  = IDLE;
            active_d = 6'd0;
            timer_d  = TMR_RELOAD;
        end

        if (state_d == IDLE) begin
            stopping_d = 1'b0;
        end
    end

    // Build the thermometer mask from the count that will be visible next cycle.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_therm
        assign therm[gi] = (32'(active_d) > 32'(gi));
    end

    // Advance the PWM counter and gate the next-cycle enable vector with it.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        pwm_on    = (duty == '0) || (pwm_cnt_d < duty);
        enable_d  = pwm_on ? therm : '0;
    end

`ifdef HEATER_CTRL_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] wdog_q, wdog_d;

    // Count the cycles with banks on; each accepted start re-arms the count.
    always_comb begin
        wdog_d    = wdog_q;
        wdog_trip = 1'b0;
        fault_d   = fault_q;
        if (start_acc) begin
            wdog_d  = '0;
            fault_d = 1'b0;
        end else if (active_q != 6'd0) begin
            if (wdog_q == WD_W'(WDOG_CYCLES - 1)) begin
                wdog_trip = 1'b1;
                wdog_d    = '0;
                fault_d   = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // Without the watchdog, this path never trips or faults.
    always_comb begin
        wdog_trip = 1'b0;
        fault_d   = 1'b0;
    end

    // An out-of-range watchdog limit has no meaning in this build.
    if (WDOG_CYCLES < 1) begin : g_wdog_limit_unused
    end
`endif

    // State and output registers; reset overrides everything, including a ramp in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            active_q   <= 6'd0;
            timer_q    <= '0;
            pwm_cnt_q  <= '0;
            stopping_q <= 1'b0;
            enable_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            timer_q    <= timer_d;
            pwm_cnt_q  <= pwm_cnt_d;
            stopping_q <= stopping_d;
            enable_q   <= enable_d;
            fault_q    <= fault_d;
        end
    end

    assign enable       = enable_q;
    assign active_count = active_q;
    assign busy         = (state_q != IDLE);
    assign fault        = fault_q;

endmodule

// File: tb/tb_heater_enable_ctrl.sv
// Testbench for heater_enable_ctrl with STEP_CYCLES=4 and PWM_BITS=4.
// The reference model tracks bank level, ramp wait, and PWM phase as plain integers.
// Watchdog scenarios run only when HEATER_CTRL_WATCHDOG_EN is defined.
module tb_heater_enable_ctrl;

    localparam int STEP  = 4;
    localparam int WDOG  = 50;
    localparam int NBANK = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [5:0]  target_banks = 6'd0;
    logic [3:0]  duty = 4'd0;
    logic [31:0] enable;
    logic [5:0]  active_count;
    logic        busy;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_level, m_wait, m_pwm, m_wd;
    bit          m_run, m_stopping, m_settled, m_fault;
    logic [31:0] m_en;

    heater_enable_ctrl #(
        .WIDTH(NBANK), .STEP_CYCLES(STEP), .PWM_BITS(4), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .target_banks(target_banks), .duty(duty),
        .enable(enable), .active_count(active_count), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] obs_vec();
        return {busy, fault, active_count, enable};
    endfunction

    function automatic logic [39:0] exp_vec();
        return {m_run, m_fault, 6'(m_level), m_en};
    endfunction

    // Move one bank toward the goal. Reaching zero ends the heating session.
    task automatic m_move(input int goal);
        if (goal > m_level) m_level++;
        else if (goal < m_level) m_level--;
        m_settled = (m_level == goal);
        m_wait = STEP - 1;
        if (m_settled && m_level == 0) begin
            m_run = 0;
            m_stopping = 0;
        end
    endtask

    // Advance one clock, update the model from the sampled inputs, and settle 1ns past the edge.
    task automatic tick();
        logic s_rst, s_start, s_stop;
        logic [3:0] s_duty;
        int tgt, goal;
        bit acc, trip;
        s_rst = rst; s_start = start; s_stop = stop; s_duty = duty;
        tgt = (int'(target_banks) > NBANK) ? NBANK : int'(target_banks);
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_level = 0; m_wait = 0; m_pwm = 0; m_wd = 0;
            m_run = 0; m_stopping = 0; m_settled = 0; m_fault = 0;
            m_en = '0;
        end else begin
            m_pwm = (m_pwm + 1) % 16;
            acc = s_start && !s_stop && (m_run ? !m_stopping : (tgt > 0));
            if (m_run && s_stop) m_stopping = 1;
            goal = m_stopping ? 0 : tgt;
            trip = 0;
`ifdef HEATER_CTRL_WATCHDOG_EN
            if (acc) begin
                m_wd = 0;
                m_fault = 0;
            end else if (m_level != 0) begin
                m_wd++;
                if (m_wd == WDOG) begin
                    trip = 1; m_fault = 1; m_wd = 0;
                    m_level = 0; m_run = 0; m_stopping = 0;
                end
            end
`endif
            if (!trip) begin
                if (!m_run) begin
                    if (acc) begin
                        m_run = 1;
                        m_move(goal);
                    end
                end else if (m_settled ? (goal != m_level) : (m_wait == 0)) begin
                    m_move(goal);
                end else if (m_wait > 0) begin
                    m_wait--;
                end
            end
            if (s_duty == 4'd0 || m_pwm < int'(s_duty))
                m_en = (m_level == 0) ? 32'd0 : 32'((64'd1 << m_level) - 64'd1);
            else
                m_en = '0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; target_banks = 6'd5;
        tick();
        rst = 1'b0; start = 1'b0;
        n_cmp++;
        if (obs_vec() !== 40'h0) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", obs_vec(), 40'h0);
        end
    endtask

    task automatic test_ramp_up();
        target_banks = 6'd3; duty = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL ramp_up k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 1 || k == 5 || k == 9) begin
                n_cmp++;
                if (active_count !== 6'((k + 3) / 4)) begin
                    n_bad++;
                    $display("FAIL ramp_up_timing k=%0d: got %0d want %0d", k, active_count, (k + 3) / 4);
                end
            end
        end
        n_cmp++;
        if (enable !== 32'h7 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ramp_up_hold: got en=%h busy=%b want en=7 busy=1", enable, busy);
        end
    endtask

    task automatic test_retarget_down();
        target_banks = 6'd1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL retarget k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == 1 || k == 5) begin
                n_cmp++;
                if (active_count !== ((k == 1) ? 6'd2 : 6'd1)) begin
                    n_bad++;
                    $display("FAIL retarget_timing k=%0d: got %0d", k, active_count);
                end
            end
        end
        n_cmp++;
        if (enable !== 32'h1 || active_count !== 6'd1) begin
            n_bad++;
            $display("FAIL retarget_hold: got en=%h cnt=%0d want en=1 cnt=1", enable, active_count);
        end
    endtask

    task automatic test_pwm();
        int n_on;
        n_on = 0;
        target_banks = 6'd2; duty = 4'd4;
        tick();
        for (int k = 0; k < 32; k++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL pwm k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (enable === 32'h3) n_on++;
        end
        n_cmp++;
        if (n_on != 8) begin
            n_bad++;
            $display("FAIL pwm_on_cycles: got %0d want 8", n_on);
        end
        duty = 4'd0;
    endtask

    task automatic test_stop();
        int k;
        target_banks = 6'd5;
        k = 0;
        while (!(m_settled && m_level == 5) && k < 40) begin
            tick();
            k++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_rampup k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (k >= 40) begin
            n_bad++;
            $display("FAIL stop_setup: timeout got level %0d want 5", active_count);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if (active_count !== 6'd4 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL stop_first: got %h want cnt=4 %h", obs_vec(), exp_vec());
        end
        for (int j = 1; j <= 20; j++) begin
            if (j == 6) start = 1'b1;
            tick();
            start = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL stop_down j=%0d: got %h want %h", j, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || active_count !== 6'd0) begin
            n_bad++;
            $display("FAIL stop_idle: got busy=%b cnt=%0d want 0 0", busy, active_count);
        end
    endtask

    task automatic test_reset_mid_ramp_and_clamp();
        int k;
        target_banks = 6'd32; start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (m_level < 2 && k < 10) begin
            tick();
            k++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs_vec() !== 40'h0) begin
            n_bad++;
            $display("FAIL reset_mid_ramp: got %h want 0", obs_vec());
        end
        target_banks = 6'd40; start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 32 * STEP + 4; j++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clamp j=%0d: got %h want %h", j, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (active_count !== 6'd32 || enable !== 32'hFFFF_FFFF || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_full: got cnt=%0d en=%h want 32 ffffffff", active_count, enable);
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 6 == 0);
            stop  = ($urandom % 50 == 0);
            rst   = ($urandom % 700 == 0);
            if ($urandom % 12 == 0) target_banks = 6'($urandom_range(0, 63));
            if ($urandom % 40 == 0) duty = 4'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random c=%0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        start = 1'b0; stop = 1'b0; rst = 1'b0;
    endtask

`ifdef HEATER_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        target_banks = 6'd2; duty = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= WDOG; k++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL wdog k=%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
            if (k == WDOG - 1) begin
                n_cmp++;
                if (fault !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wdog_early: got fault=%b want 0", fault);
                end
            end
        end
        n_cmp++;
        if (fault !== 1'b1 || enable !== 32'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_trip: got fault=%b en=%h busy=%b want 1 0 0", fault, enable, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (fault !== 1'b0 || active_count !== 6'd1) begin
            n_bad++;
            $display("FAIL wdog_restart: got fault=%b cnt=%0d want 0 1", fault, active_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp_up();
        test_retarget_down();
        test_pwm();
        test_stop();
        test_reset_mid_ramp_and_clamp();
        test_random();
`ifdef HEATER_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
